// File: rtl/suma_pkg.sv
// Shared definitions for the calculator add/subtract/accumulate datapath:
// op encoding, FSM state encoding and the decimal limit helper.
package suma_pkg;

  // Request opcodes as they arrive on the op port.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  // Request lifecycle: accept, compute, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // 10**d, evaluated at elaboration to derive the decimal magnitude limit.
  function automatic logic [63:0] pow10(input int d);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < d; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/suma_range_chk.sv
// Combinational range check of a widened signed sum against +/-max.
// Produces in_range and the value to report when out of range.
// Build option: SUMA_ACC_SAT_EN selects saturation to +/-max; without it
// an out-of-range result is reported as all ones.
module suma_range_chk #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH+1:0] i_s,
  input  logic [WIDTH-1:0] i_max,
  output logic             o_in_range,
  output logic [WIDTH-1:0] o_fix_val
);

  logic signed [WIDTH+1:0] w_max_pos;
  logic signed [WIDTH+1:0] w_max_neg;
  logic signed [WIDTH+1:0] w_s;

  assign w_s       = $signed(i_s);
  assign w_max_pos = $signed({2'b00, i_max});
  assign w_max_neg = -w_max_pos;

  // Inclusive window check on the widened sum, so no carry is lost.
  assign o_in_range = (w_s <= w_max_pos) && (w_s >= w_max_neg);

  // Replacement value; an out-of-range sum is never zero, so the sign bit
  // alone decides the clamp direction.
`ifdef SUMA_ACC_SAT_EN
  assign o_fix_val = w_s[WIDTH+1] ? w_max_neg[WIDTH-1:0] : i_max;
`else
  assign o_fix_val = '1;
`endif

endmodule

// File: rtl/suma_acc.sv
// Signed add/subtract/accumulate unit with valid/ready on both sides,
// a three-state sequencer, a running accumulator and a decimal range limit
// MAX = 10**DIGITS - 1.
// Build option: SUMA_ACC_SAT_EN (saturating out-of-range results; legacy
// all-ones error value when undefined).
//
// Handshake: a request transfers on a rising edge where valid_in and
// ready_in are both high; a result transfers on a rising edge where
// valid_out and ready_out are both high. Each side holds its payload
// stable while its valid is high and not yet accepted.
module suma_acc
  import suma_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] d_out,
  output logic             ovrflow,
  output logic             ovr_sticky,
  output logic [WIDTH-1:0] acc_out,
  output logic [1:0]       dbg_state
);

  localparam logic [63:0]      MAX_L = pow10(DIGITS) - 64'd1;
  localparam logic [WIDTH-1:0] MAX   = MAX_L[WIDTH-1:0];

  // MAX must be representable as a positive WIDTH-bit two's-complement value.
  if (MAX_L > ((64'd1 << (WIDTH - 1)) - 64'd1)) begin : g_max_chk
    $error("suma_acc: 10**DIGITS-1 does not fit in WIDTH-1 bits");
  end

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_n1;
  logic [WIDTH-1:0] r_n2;
  logic [WIDTH-1:0] r_d_out;
  logic             r_ovf;
  logic             r_sticky;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH+1:0] w_s;
  logic [WIDTH+1:0] w_a;
  logic [WIDTH+1:0] w_b;
  logic [WIDTH+1:0] w_acc;
  logic             w_in_range;
  logic [WIDTH-1:0] w_fix_val;

  assign w_a   = {{2{r_n1[WIDTH-1]}}, r_n1};
  assign w_b   = {{2{r_n2[WIDTH-1]}}, r_n2};
  assign w_acc = {{2{r_acc[WIDTH-1]}}, r_acc};

  // Widened sum for the latched request; two guard bits keep it exact.
  always_comb begin
    w_s = '0;
    case (r_op)
      OP_ADD:  w_s = w_a + w_b;
      OP_SUB:  w_s = w_a - w_b;
      OP_ACC:  w_s = w_acc + w_a;
      default: w_s = '0;
    endcase
  end

  suma_range_chk #(
    .WIDTH(WIDTH)
  ) u_range_chk (
    .i_s       (w_s),
    .i_max     (MAX),
    .o_in_range(w_in_range),
    .o_fix_val (w_fix_val)
  );

  // Sequencer plus request latch, result registers and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_n1     <= '0;
      r_n2     <= '0;
      r_d_out  <= '0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_op    <= op_t'(op);
            r_n1    <= n1;
            r_n2    <= n2;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_d_out <= w_in_range ? w_s[WIDTH-1:0] : w_fix_val;
          r_ovf   <= ~w_in_range;
          if (!w_in_range) begin
            r_sticky <= 1'b1;
          end
          if (r_op == OP_ACC) begin
            if (w_in_range) begin
              r_acc <= w_s[WIDTH-1:0];
            end
`ifdef SUMA_ACC_SAT_EN
            else begin
              r_acc <= w_fix_val;
            end
`endif
          end
          // CLR always yields zero, which is in range, so this never
          // competes with the sticky set above.
          if (r_op == OP_CLR) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ready_out) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_in   = (r_state == ST_IDLE);
  assign valid_out  = (r_state == ST_HOLD);
  assign d_out      = r_d_out;
  assign ovrflow    = r_ovf;
  assign ovr_sticky = r_sticky;
  assign acc_out    = r_acc;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_suma_acc.sv
// Directed bench for suma_acc with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_suma_acc;

  localparam int W = 28;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic         ready_in;
  logic [1:0]   op;
  logic [W-1:0] n1;
  logic [W-1:0] n2;
  logic         valid_out;
  logic         ready_out;
  logic [W-1:0] d_out;
  logic         ovrflow;
  logic         ovr_sticky;
  logic [W-1:0] acc_out;
  logic [1:0]   dbg_state;

  int n_vec;
  int n_err;

  // Expected values that differ between builds.
`ifdef SUMA_ACC_SAT_EN
  localparam int E_POS_OVF = 99_999_999;
  localparam int E_NEG_OVF = -99_999_999;
  localparam int E_ACC_OVF = 99_999_999;
`else
  localparam int E_POS_OVF = 268_435_455;
  localparam int E_NEG_OVF = 268_435_455;
  localparam int E_ACC_OVF = 99_999_991;
`endif

  suma_acc #(.WIDTH(W), .DIGITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .op        (op),
    .n1        (n1),
    .n2        (n2),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .d_out     (d_out),
    .ovrflow   (ovrflow),
    .ovr_sticky(ovr_sticky),
    .acc_out   (acc_out),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] wv(input int v);
    logic [31:0] t;
    t = v;
    return {4'h0, t[W-1:0]};
  endfunction

  // One full transaction with ready_out held high.
  task automatic do_op(input string tag, input logic [1:0] o, input int a, input int b,
                       input int e_d, input logic e_ovf, input int e_acc, input logic e_sticky);
    logic [31:0] ta;
    logic [31:0] tb;
    int guard;
    ta = a;
    tb = b;
    guard = 0;
    while (!ready_in && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready_in"}, {31'd0, ready_in}, 32'd1);
    valid_in = 1'b1;
    op       = o;
    n1       = ta[W-1:0];
    n2       = tb[W-1:0];
    @(posedge clk); #1;
    valid_in = 1'b0;
    check({tag, "_calc_valid_out"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_calc_ready_in"}, {31'd0, ready_in}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_out"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_d_out"}, {4'h0, d_out}, wv(e_d));
    check({tag, "_ovrflow"}, {31'd0, ovrflow}, {31'd0, e_ovf});
    check({tag, "_acc_out"}, {4'h0, acc_out}, wv(e_acc));
    check({tag, "_sticky"}, {31'd0, ovr_sticky}, {31'd0, e_sticky});
    @(posedge clk); #1;
    check({tag, "_back_idle"}, {31'd0, ready_in}, 32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    op        = 2'b00;
    n1        = '0;
    n2        = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", {4'h0, d_out}, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_ovrflow", {31'd0, ovrflow}, 32'd0);
    check("rst_sticky", {31'd0, ovr_sticky}, 32'd0);
    check("rst_acc", {4'h0, acc_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready_in", {31'd0, ready_in}, 32'd1);

    // Largest in-range sum
    do_op("add_max", 2'b00, 50_000_000, 49_999_999, 99_999_999, 1'b0, 0, 1'b0);
    // Positive overflow by one
    do_op("add_ovf", 2'b00, 99_999_999, 1, E_POS_OVF, 1'b1, 0, 1'b1);
    // Negative overflow by one
    do_op("sub_ovf", 2'b01, -99_999_999, 1, E_NEG_OVF, 1'b1, 0, 1'b1);
    // In-range op leaves sticky set
    do_op("sub_ok", 2'b01, 5, 9, -4, 1'b0, 0, 1'b1);
    // Clear
    do_op("clr", 2'b11, 123, 456, 0, 1'b0, 0, 1'b0);

    // Accumulate sequence
    do_op("acc1", 2'b10, 10, 777, 10, 1'b0, 10, 1'b0);
    do_op("acc2", 2'b10, -25, 0, -15, 1'b0, -15, 1'b0);
    do_op("acc3", 2'b10, 7, 0, -8, 1'b0, -8, 1'b0);
    do_op("acc4", 2'b10, 99_999_999, 0, 99_999_991, 1'b0, 99_999_991, 1'b0);
    // Accumulator overflow: legacy keeps acc, saturating build clamps it
    do_op("acc_ovf", 2'b10, 10, 0, E_POS_OVF, 1'b1, E_ACC_OVF, 1'b1);

    // Back-pressure in HOLD with valid_in toggling
    ready_out = 1'b0;
    do_op_bp();

    // Reset during CALC of an ACC
    valid_in = 1'b1;
    op       = 2'b10;
    n1       = 28'd5;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("abort_in_calc", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_d_out", {4'h0, d_out}, 32'd0);
    check("abort_acc", {4'h0, acc_out}, 32'd0);
    check("abort_valid_out", {31'd0, valid_out}, 32'd0);
    check("abort_ovrflow", {31'd0, ovrflow}, 32'd0);
    check("abort_sticky", {31'd0, ovr_sticky}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_in", {31'd0, ready_in}, 32'd1);
    do_op("after_abort_add", 2'b00, 1, 2, 3, 1'b0, 0, 1'b0);
    do_op("after_abort_acc", 2'b10, 4, 0, 4, 1'b0, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ADD 3+4 held in HOLD for 10 cycles with ready_out low.
  task automatic do_op_bp();
    valid_in = 1'b1;
    op       = 2'b00;
    n1       = 28'd3;
    n2       = 28'd4;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("bp_enter_hold", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      valid_in = ~valid_in;
      op       = 2'b01;
      n1       = 28'd100 + 28'(i);
      n2       = 28'd1;
      @(posedge clk); #1;
      check("bp_d_out", {4'h0, d_out}, 32'd7);
      check("bp_ready_in", {31'd0, ready_in}, 32'd0);
      check("bp_valid_out", {31'd0, valid_out}, 32'd1);
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {31'd0, ready_in}, 32'd1);
    check("bp_release_valid", {31'd0, valid_out}, 32'd0);
    // Nothing was accepted while blocked: stays idle with no request pending.
    @(posedge clk); #1;
    check("bp_no_extra_req", {30'd0, dbg_state}, 32'd0);
    check("bp_acc_kept", {4'h0, acc_out}, wv(E_ACC_OVF));
  endtask

endmodule
